// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input, reload control, and instruction-memory
// program port / status outputs of the boot-time image loader.
// master = host/test side, slave = imem_loader.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        reload;
  logic        prog_en;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        start;
  logic        load_busy;
  logic        load_error;

  modport master (
    output rx_valid, rx_data, reload,
    input  prog_en, prog_addr, prog_data, start, load_busy, load_error
  );

  modport slave (
    input  rx_valid, rx_data, reload,
    output prog_en, prog_addr, prog_data, start, load_busy, load_error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time sequencer for the instruction memory program port.
// Reads a 4-byte little-endian word count, then packs each following group of
// 4 bytes into a 32-bit word and writes it with a one-cycle prog_en pulse.
// The core start enable rises only after a complete, valid image.
// Optional trailing 8-bit checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned IMEM_DEPTH = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(IMEM_DEPTH + 1);

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERROR
  } state_e;

  // State entered once the image body (possibly empty) has been consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e BODY_EXIT = S_CSUM;
`else
  localparam state_e BODY_EXIT = S_DONE;
`endif

  state_e           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [23:0]      shift_q, shift_d;      // bytes 0..2 of the group in progress
  logic [31:0]      len_q, len_d;
  logic             prog_en_q, prog_en_d;
  logic [31:0]      prog_addr_q, prog_addr_d;
  logic [31:0]      prog_data_q, prog_data_d;
  logic             start_q, start_d;
  logic             load_busy_q, load_busy_d;
  logic             load_error_q, load_error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif
  logic [31:0]      word_full;
  logic             last_byte;

  // Next-state and registered-output computation for the loader FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_idx_d  = word_idx_q;
    shift_d     = shift_q;
    len_d       = len_q;
    prog_en_d   = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    word_full   = {bus.rx_data, shift_q};
    last_byte   = (byte_cnt_q == 2'd3);

    if (bus.reload) begin
      // Reload wins over a same-cycle byte and cancels any write it would cause.
      state_d    = S_HDR;
      byte_cnt_d = 2'd0;
      word_idx_d = '0;
    end else if (bus.rx_valid) begin
      case (state_q)
        S_HDR: begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {bus.rx_data, shift_q[23:8]};
          if (last_byte) begin
            len_d      = word_full;
            word_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d      = 8'h00;
`endif
            if (word_full == 32'd0)                  state_d = BODY_EXIT;
            else if (word_full > 32'(IMEM_DEPTH))    state_d = S_ERROR;
            else                                     state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {bus.rx_data, shift_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = sum_q + bus.rx_data;
`endif
          if (last_byte) begin
            prog_en_d   = 1'b1;
            prog_addr_d = BASE_ADDR + (32'(word_idx_q) << 2);
            prog_data_d = word_full;
            word_idx_d  = word_idx_q + IDX_W'(1);
            if (32'(word_idx_q) == len_q - 32'd1) state_d = BODY_EXIT;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: state_d = (bus.rx_data == sum_q) ? S_DONE : S_ERROR;
`endif
        default: ;  // DONE and ERROR ignore all bytes
      endcase
    end

    // start waits one cycle past the final write so it never overlaps prog_en.
    start_d      = (state_d == S_DONE) && !prog_en_d;
    load_error_d = (state_d == S_ERROR);
`ifdef IMEM_LOADER_CHECKSUM_EN
    load_busy_d  = (state_d == S_LOAD) || (state_d == S_CSUM);
`else
    load_busy_d  = (state_d == S_LOAD);
`endif
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_HDR;
      byte_cnt_q   <= 2'd0;
      word_idx_q   <= '0;
      shift_q      <= 24'd0;
      len_q        <= 32'd0;
      prog_en_q    <= 1'b0;
      prog_addr_q  <= 32'd0;
      prog_data_q  <= 32'd0;
      start_q      <= 1'b0;
      load_busy_q  <= 1'b0;
      load_error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= 8'h00;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      shift_q      <= shift_d;
      len_q        <= len_d;
      prog_en_q    <= prog_en_d;
      prog_addr_q  <= prog_addr_d;
      prog_data_q  <= prog_data_d;
      start_q      <= start_d;
      load_busy_q  <= load_busy_d;
      load_error_q <= load_error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign bus.prog_en    = prog_en_q;
  assign bus.prog_addr  = prog_addr_q;
  assign bus.prog_data  = prog_data_q;
  assign bus.start      = start_q;
  assign bus.load_busy  = load_busy_q;
  assign bus.load_error = load_error_q;
endmodule
